// File: rtl/plab5_mcore_mem_req_tracker_pkg.sv
// rtl/plab5_mcore_mem_req_tracker_pkg.sv - shared constants and memory-message width helpers
//
// Purpose: local constants for the request tracker plus the memory message
// width calculations (type, opaque, addr, len, data fields for requests;
// type, opaque, test, len, data fields for responses).
package plab5_mcore_mem_req_tracker_pkg;

  localparam int domain_nbits        = 1;
  localparam int mem_msg_type_nbits  = 3;
  localparam int mem_resp_test_nbits = 2;

  // Length field addresses bytes within one data word.
  function automatic int mem_len_nbits(input int md);
    return $clog2(md / 8);
  endfunction

  function automatic int mem_req_msg_nbits(input int o, input int a, input int md);
    return mem_msg_type_nbits + o + a + mem_len_nbits(md) + md;
  endfunction

  function automatic int mem_resp_msg_nbits(input int o, input int md);
    return mem_msg_type_nbits + o + mem_resp_test_nbits + mem_len_nbits(md) + md;
  endfunction

  // Counters must hold 0..depth inclusive.
  function automatic int count_nbits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_req_tracker_if.sv
// rtl/plab5_mcore_mem_req_tracker_if.sv - val/rdy message channel
//
// Purpose: one val/rdy channel carrying an nbits-wide message.
// Ports (signals):
//   msg  message payload, driven by the master
//   val  message valid, driven by the master
//   rdy  receiver ready, driven by the slave
interface plab5_mcore_mem_req_tracker_if #(
  parameter int nbits = 1
);

  logic [nbits-1:0] msg;
  logic             val;
  logic             rdy;

  modport master (output msg, output val, input rdy);
  modport slave  (input msg, input val, output rdy);

endinterface

// File: rtl/plab5_mcore_domain_tracker.sv
// rtl/plab5_mcore_domain_tracker.sv - in-order FIFO of 1-bit security domains
//
// Purpose: remembers the domain of each in-flight memory request, oldest first.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   push, push_data   record a newly issued request's domain
//   pop          retire the oldest entry
//   full, empty  occupancy flags
//   count        entries held (0..depth)
//   head         oldest domain, 0 when empty
module plab5_mcore_domain_tracker #(
  parameter int depth = 4
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count,
  output logic                     head
);

  localparam int ptr_nbits = $clog2(depth);
  localparam int cnt_nbits = ptr_nbits + 1;

  logic [depth-1:0]     mem;
  logic [ptr_nbits-1:0] head_ptr;
  logic [ptr_nbits-1:0] tail_ptr;
  logic                 push_fire;
  logic                 pop_fire;

  assign full      = (count == cnt_nbits'(depth));
  assign empty     = (count == '0);
  assign head      = empty ? 1'b0 : mem[head_ptr];
  assign push_fire = push & ~full;
  assign pop_fire  = pop & ~empty;

  // Pointers wrap naturally (depth is a power of 2); count disambiguates full/empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem      <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push_fire) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (pop_fire) head_ptr <= head_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/plab5_mcore_mem_req_queue.sv
// rtl/plab5_mcore_mem_req_queue.sv - normal (non-bypass) val/rdy queue
//
// Purpose: depth-entry FIFO; an entry enqueued at edge N is visible on the
// dequeue side after edge N. Enqueue and dequeue may fire in the same cycle.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   enq_val/rdy/msg     enqueue side; enq_rdy = !full
//   deq_val/rdy/msg     dequeue side; deq_val = !empty
module plab5_mcore_mem_req_queue #(
  parameter int nbits = 1,
  parameter int depth = 2
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_val,
  output logic             enq_rdy,
  input  logic [nbits-1:0] enq_msg,
  output logic             deq_val,
  input  logic             deq_rdy,
  output logic [nbits-1:0] deq_msg
);

  localparam int ptr_nbits = $clog2(depth);
  localparam int cnt_nbits = ptr_nbits + 1;

  logic [nbits-1:0]     mem [depth];
  logic [ptr_nbits-1:0] enq_ptr;
  logic [ptr_nbits-1:0] deq_ptr;
  logic [cnt_nbits-1:0] count;
  logic                 enq_fire;
  logic                 deq_fire;

  assign enq_rdy  = (count != cnt_nbits'(depth));
  assign deq_val  = (count != '0);
  assign deq_msg  = mem[deq_ptr];
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (enq_fire) enq_ptr <= enq_ptr + 1'b1;
      if (deq_fire) deq_ptr <= deq_ptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[enq_ptr] <= enq_msg;
  end

endmodule

// File: rtl/plab5_mcore_mem_req_tracker.sv
// rtl/plab5_mcore_mem_req_tracker.sv - buffers memory requests and tags responses with their domain
//
// Purpose: queues translated memory requests with their security domain,
// records the domain of each request issued to memory, and labels each
// in-order response with the domain of the request that produced it.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   req_domain       domain of the request on req_in
//   req_in           translated request channel (slave)
//   req_out          request channel to memory (master)
//   req_out_domain   domain of the head-of-queue request (0 when empty)
//   resp_in          memory response channel (slave)
//   resp_out         response channel to the translator (master)
//   resp_domain      domain of the oldest in-flight request (0 when none)
//   outstanding      in-flight request count
//   spurious_resp    sticky: a response arrived with nothing in flight
module plab5_mcore_mem_req_tracker
  import plab5_mcore_mem_req_tracker_pkg::*;
#(
  parameter int opaque_nbits      = 8,
  parameter int addr_nbits        = 32,
  parameter int mem_data_nbits    = 128,
  parameter int req_depth         = 2,
  parameter int max_outstanding   = 4,
  parameter int mem_reqmsg_nbits  = mem_req_msg_nbits(opaque_nbits, addr_nbits, mem_data_nbits),
  parameter int mem_respmsg_nbits = mem_resp_msg_nbits(opaque_nbits, mem_data_nbits)
)(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      req_domain,
  plab5_mcore_mem_req_tracker_if.slave              req_in,
  plab5_mcore_mem_req_tracker_if.master             req_out,
  output logic                                      req_out_domain,
  plab5_mcore_mem_req_tracker_if.slave              resp_in,
  plab5_mcore_mem_req_tracker_if.master             resp_out,
  output logic                                      resp_domain,
  output logic [count_nbits(max_outstanding)-1:0]   outstanding,
  output logic                                      spurious_resp
);

  localparam int q_nbits = domain_nbits + mem_reqmsg_nbits;

  logic [q_nbits-1:0]           q_enq_msg;
  logic [q_nbits-1:0]           q_deq_msg;
  logic                         q_deq_val;
  logic                         q_deq_rdy;
  logic                         trk_full;
  logic                         trk_empty;
  logic                         trk_push;
  logic                         trk_pop;
  logic                         trk_head;
  logic [mem_respmsg_nbits-1:0] resp_msg;

  assign q_enq_msg = {req_domain, req_in.msg};

  plab5_mcore_mem_req_queue #(
    .nbits (q_nbits),
    .depth (req_depth)
  ) req_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (req_in.val),
    .enq_rdy (req_in.rdy),
    .enq_msg (q_enq_msg),
    .deq_val (q_deq_val),
    .deq_rdy (q_deq_rdy),
    .deq_msg (q_deq_msg)
  );

  // Issue is blocked while the tracker is full, even if a response retires
  // this cycle; this keeps resp_out.rdy out of the req_out.val cone.
  assign req_out.val    = q_deq_val & ~trk_full;
  assign req_out.msg    = q_deq_msg[mem_reqmsg_nbits-1:0];
  assign req_out_domain = q_deq_val ? q_deq_msg[q_nbits-1] : 1'b0;
  assign q_deq_rdy      = req_out.rdy & ~trk_full;

  assign trk_push = req_out.val & req_out.rdy;
  assign trk_pop  = resp_out.val & resp_out.rdy;

  plab5_mcore_domain_tracker #(
    .depth (max_outstanding)
  ) domain_tracker (
    .clk       (clk),
    .reset     (reset),
    .push      (trk_push),
    .push_data (req_out_domain),
    .pop       (trk_pop),
    .full      (trk_full),
    .empty     (trk_empty),
    .count     (outstanding),
    .head      (trk_head)
  );

  // Responses with nothing in flight are swallowed (rdy forced high) so a
  // stray response can never carry a borrowed domain to the translator.
  assign resp_msg     = resp_in.msg;
  assign resp_out.msg = resp_msg;
  assign resp_out.val = resp_in.val & ~trk_empty;
  assign resp_in.rdy  = trk_empty ? 1'b1 : resp_out.rdy;
  assign resp_domain  = trk_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spurious_resp <= 1'b0;
    end else if (resp_in.val & trk_empty) begin
      spurious_resp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_req_tracker.sv
// tb/tb_plab5_mcore_mem_req_tracker.sv - table-driven bench for the memory request tracker
module tb_plab5_mcore_mem_req_tracker;
  import plab5_mcore_mem_req_tracker_pkg::*;

  localparam int REQ_W    = mem_req_msg_nbits(8, 32, 128);
  localparam int RESP_W   = mem_resp_msg_nbits(8, 128);
  localparam int ADDR_LSB = 128 + 4;

  typedef struct {
    logic        rqv;
    logic        dom;
    logic [31:0] addr;
    logic        ordy;
    logic        rsv;
    logic        rrdy;
    logic        irdy;
    logic        oval;
    logic        odom;
    logic [31:0] oaddr;
    logic        rsval;
    logic        rsirdy;
    logic        rsdom;
    logic [2:0]  outs;
    logic        spur;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       req_domain;
  logic       req_out_domain;
  logic       resp_domain;
  logic [2:0] outstanding;
  logic       spurious_resp;

  plab5_mcore_mem_req_tracker_if #(.nbits(REQ_W))  req_in_if ();
  plab5_mcore_mem_req_tracker_if #(.nbits(REQ_W))  req_out_if ();
  plab5_mcore_mem_req_tracker_if #(.nbits(RESP_W)) resp_in_if ();
  plab5_mcore_mem_req_tracker_if #(.nbits(RESP_W)) resp_out_if ();

  plab5_mcore_mem_req_tracker dut (
    .clk            (clk),
    .reset          (reset),
    .req_domain     (req_domain),
    .req_in         (req_in_if),
    .req_out        (req_out_if),
    .req_out_domain (req_out_domain),
    .resp_in        (resp_in_if),
    .resp_out       (resp_out_if),
    .resp_domain    (resp_domain),
    .outstanding    (outstanding),
    .spurious_resp  (spurious_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  function automatic logic [REQ_W-1:0] make_req(input logic [31:0] addr);
    logic [REQ_W-1:0] m;
    m = '0;
    m[ADDR_LSB +: 32] = addr;
    m[31:0] = ~addr;
    return m;
  endfunction

  function automatic vec_t mk(
    input logic rqv, input logic dom, input logic [31:0] addr, input logic ordy,
    input logic rsv, input logic rrdy, input logic irdy, input logic oval,
    input logic odom, input logic [31:0] oaddr, input logic rsval, input logic rsirdy,
    input logic rsdom, input logic [2:0] outs, input logic spur);
    vec_t v;
    v.rqv = rqv; v.dom = dom; v.addr = addr; v.ordy = ordy; v.rsv = rsv; v.rrdy = rrdy;
    v.irdy = irdy; v.oval = oval; v.odom = odom; v.oaddr = oaddr; v.rsval = rsval;
    v.rsirdy = rsirdy; v.rsdom = rsdom; v.outs = outs; v.spur = spur;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [RESP_W-1:0] r;
    r = '0;
    r[15:0] = 16'(idx);
    req_domain      = v.dom;
    req_in_if.val   = v.rqv;
    req_in_if.msg   = make_req(v.addr);
    req_out_if.rdy  = v.ordy;
    resp_in_if.val  = v.rsv;
    resp_in_if.msg  = r;
    resp_out_if.rdy = v.rrdy;
  endtask

  task automatic run_row(input vec_t v, input int idx);
    @(negedge clk);
    apply(v, idx);
    #1;
    check("req_in_rdy",     idx, 32'(req_in_if.rdy),   32'(v.irdy));
    check("req_out_val",    idx, 32'(req_out_if.val),  32'(v.oval));
    check("req_out_domain", idx, 32'(req_out_domain),  32'(v.odom));
    if (v.oval)
      check("req_out_addr", idx, req_out_if.msg[ADDR_LSB +: 32], v.oaddr);
    check("resp_out_val",   idx, 32'(resp_out_if.val), 32'(v.rsval));
    check("resp_in_rdy",    idx, 32'(resp_in_if.rdy),  32'(v.rsirdy));
    check("resp_domain",    idx, 32'(resp_domain),     32'(v.rsdom));
    if (v.rsval)
      check("resp_out_tag", idx, 32'(resp_out_if.msg[15:0]), 32'(idx));
    check("outstanding",    idx, 32'(outstanding),     32'(v.outs));
    check("spurious_resp",  idx, 32'(spurious_resp),   32'(v.spur));
  endtask

  initial begin
    //                rqv dom addr     ordy rsv rrdy| irdy oval odom oaddr    rsval rsirdy rsdom outs spur
    // single request, response one cycle after issue
    vecs.push_back(mk(1, 1, 32'h1000, 1, 0, 1,  1, 0, 0, 32'h0,    0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 1,  1, 1, 1, 32'h1000, 0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 0, 0, 32'h0,    1, 1, 1, 3'd1, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 1,  1, 0, 0, 32'h0,    0, 1, 0, 3'd0, 0));
    // domains 0,1,1,0 back to back, fifth (domain 1) held while tracker full
    vecs.push_back(mk(1, 0, 32'h2000, 1, 0, 1,  1, 0, 0, 32'h0,    0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(1, 1, 32'h2010, 1, 0, 1,  1, 1, 0, 32'h2000, 0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(1, 1, 32'h2020, 1, 0, 1,  1, 1, 1, 32'h2010, 0, 1, 0, 3'd1, 0));
    vecs.push_back(mk(1, 0, 32'h2030, 1, 0, 1,  1, 1, 1, 32'h2020, 0, 1, 0, 3'd2, 0));
    vecs.push_back(mk(1, 1, 32'h2040, 1, 0, 1,  1, 1, 0, 32'h2030, 0, 1, 0, 3'd3, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 1,  1, 0, 1, 32'h0,    0, 1, 0, 3'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 0,  1, 0, 1, 32'h0,    1, 0, 0, 3'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 0, 1, 32'h0,    1, 1, 0, 3'd4, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 1, 1, 32'h2040, 1, 1, 1, 3'd3, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 0, 0, 32'h0,    1, 1, 1, 3'd3, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 0, 0, 32'h0,    1, 1, 0, 3'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 0, 0, 32'h0,    1, 1, 1, 3'd1, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 1,  1, 0, 0, 32'h0,    0, 1, 0, 3'd0, 0));
    // memory stalls: queue fills, then drains at one per cycle with wrap
    vecs.push_back(mk(1, 0, 32'h3000, 0, 0, 1,  1, 0, 0, 32'h0,    0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(1, 1, 32'h3010, 0, 0, 1,  1, 1, 0, 32'h3000, 0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(1, 0, 32'h3020, 0, 0, 1,  0, 1, 0, 32'h3000, 0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(1, 0, 32'h3020, 1, 0, 1,  0, 1, 0, 32'h3000, 0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(1, 0, 32'h3020, 1, 0, 1,  1, 1, 1, 32'h3010, 0, 1, 0, 3'd1, 0));
    vecs.push_back(mk(1, 1, 32'h3030, 1, 1, 1,  1, 1, 0, 32'h3020, 1, 1, 0, 3'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 1, 1, 32'h3030, 1, 1, 1, 3'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 0, 0, 32'h0,    1, 1, 0, 3'd2, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 1,  1, 0, 0, 32'h0,    1, 1, 1, 3'd1, 0));
    // spurious response with nothing in flight, flag sticks
    vecs.push_back(mk(0, 0, 32'h0,    1, 1, 0,  1, 0, 0, 32'h0,    0, 1, 0, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 1,  1, 0, 0, 32'h0,    0, 1, 0, 3'd0, 1));
    vecs.push_back(mk(1, 1, 32'h4000, 1, 0, 1,  1, 0, 0, 32'h0,    0, 1, 0, 3'd0, 1));
    vecs.push_back(mk(0, 0, 32'h0,    1, 0, 1,  1, 1, 1, 32'h4000, 0, 1, 0, 3'd0, 1));

    reset = 1'b1;
    apply(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 3'd0, 0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset req_out_val",    -1, 32'(req_out_if.val),  32'd0);
    check("reset resp_out_val",   -1, 32'(resp_out_if.val), 32'd0);
    check("reset req_out_domain", -1, 32'(req_out_domain),  32'd0);
    check("reset resp_domain",    -1, 32'(resp_domain),     32'd0);
    check("reset outstanding",    -1, 32'(outstanding),     32'd0);
    check("reset spurious_resp",  -1, 32'(spurious_resp),   32'd0);
    check("reset req_in_rdy",     -1, 32'(req_in_if.rdy),   32'd1);

    for (int i = 0; i < vecs.size(); i++) run_row(vecs[i], i);

    // build up three in flight behind the domain-1 request already issued
    run_row(mk(1, 0, 32'h5000, 1, 0, 1,  1, 0, 0, 32'h0,    0, 1, 1, 3'd1, 1), 100);
    run_row(mk(1, 1, 32'h5010, 1, 0, 1,  1, 1, 0, 32'h5000, 0, 1, 1, 3'd1, 1), 101);
    run_row(mk(1, 0, 32'h5020, 1, 0, 1,  1, 1, 1, 32'h5010, 0, 1, 1, 3'd2, 1), 102);
    run_row(mk(0, 0, 32'h0,    0, 1, 0,  1, 1, 0, 32'h5020, 1, 0, 1, 3'd3, 1), 103);

    // asynchronous reset between clock edges
    #1 reset = 1'b1;
    #1;
    check("async outstanding",    104, 32'(outstanding),     32'd0);
    check("async req_out_val",    104, 32'(req_out_if.val),  32'd0);
    check("async resp_out_val",   104, 32'(resp_out_if.val), 32'd0);
    check("async spurious_resp",  104, 32'(spurious_resp),   32'd0);
    check("async req_out_domain", 104, 32'(req_out_domain),  32'd0);
    check("async resp_domain",    104, 32'(resp_domain),     32'd0);
    check("async req_in_rdy",     104, 32'(req_in_if.rdy),   32'd1);

    // stale response for a pre-reset request is dropped and flagged
    @(negedge clk);
    reset = 1'b0;
    resp_out_if.rdy = 1'b1;
    #1;
    check("stale resp_out_val",   105, 32'(resp_out_if.val), 32'd0);
    check("stale resp_in_rdy",    105, 32'(resp_in_if.rdy),  32'd1);
    check("stale spurious pre",   105, 32'(spurious_resp),   32'd0);
    @(negedge clk);
    resp_in_if.val = 1'b0;
    #1;
    check("stale spurious post",  106, 32'(spurious_resp),   32'd1);
    check("stale outstanding",    106, 32'(outstanding),     32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_req_tracker.md
Name: plab5_mcore_mem_req_tracker

Overview:
Sits between the proc-to-mem message translator and the memory port, on the memory side. Buffers translated 128-bit memory requests together with their security-domain bit. Records the domain of every request issued to memory and tags each in-order memory response with that domain. The recovered domain is the resp_domain input of the translator, so response data is never labelled with a domain other than the one that issued the request.

Parameters:
opaque_nbits, 8, opaque field width
addr_nbits, 32, address field width
mem_data_nbits, 128, memory data width
req_depth, 2, request queue entries (power of 2, >=2)
max_outstanding, 4, in-flight request limit (power of 2, >=2)
mem_reqmsg_nbits, VC_MEM_REQ_MSG_NBITS(o,a,md), request message width
mem_respmsg_nbits, VC_MEM_RESP_MSG_NBITS(o,md), response message width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_domain  in  1  domain of the incoming request
req_in_msg  in  mem_reqmsg_nbits  translated request
req_in_val  in  1  request valid
req_in_rdy  out  1  request ready
req_out_msg  out  mem_reqmsg_nbits  request to memory
req_out_val  out  1  valid
req_out_rdy  in  1  ready
req_out_domain  out  1  domain of the head-of-queue request
resp_in_msg  in  mem_respmsg_nbits  memory response
resp_in_val  in  1  valid
resp_in_rdy  out  1  ready
resp_out_msg  out  mem_respmsg_nbits  response to translator (equals resp_in_msg)
resp_out_val  out  1  valid
resp_out_rdy  in  1  ready
resp_domain  out  1  domain of the oldest in-flight request
outstanding  out  clog2(max_outstanding)+1  in-flight count
spurious_resp  out  1  sticky error flag

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset clears both queues, outstanding and spurious_resp. All val outputs and req_out_domain/resp_domain reset to 0.
- Handshakes are val/rdy; a transfer occurs when val & rdy are high at a posedge. val never depends combinationally on rdy of the same interface.
- Request queue:
  - Normal (non-bypass) FIFO of {domain, msg}, req_depth entries.
  - req_in_rdy = !full. A request accepted at edge N appears on req_out at edge N+1 at the earliest.
  - Enqueue and dequeue in the same cycle are legal, including when full (rdy stays high only if not full; dequeue frees the slot next cycle).
- Issue gate:
  - req_out_val = queue non-empty & tracker not full.
  - When tracker is full, req_out_val = 0 regardless of req_out_rdy; there is no full-with-pop-same-cycle bypass, so there is no combinational path from resp_out_rdy to req_out_val.
- Tracker (in-order domain FIFO, max_outstanding entries):
  - Pushes req_out_domain on a req_out handshake.
  - Pops on a resp_out handshake.
  - Simultaneous push and pop leaves outstanding unchanged; the head advances and the tail writes.
  - Pointers wrap modulo max_outstanding; the count is kept separately (0..max_outstanding).
- Response path (combinational, zero latency):
  - resp_out_msg = resp_in_msg.
  - resp_out_val = resp_in_val & tracker non-empty.
  - resp_in_rdy = resp_out_rdy when tracker non-empty, else 1.
  - resp_domain = tracker head domain; 0 when empty.
- Spurious response: resp_in_val while tracker is empty is consumed and dropped, not forwarded. spurious_resp is set and stays set until reset.
- Reset mid-operation: all in-flight state is lost. Responses arriving after reset for pre-reset requests are treated as spurious.
- The request message contents are not inspected or modified.

Decomposition:
- Message widths and field macros come from the existing vc-mem-msgs definitions; no new package is needed.
- Local constants: domain width 1, count width clog2(max_outstanding)+1.
- Sub-module: plab5_mcore_domain_tracker, a parameterised 1-bit-wide FIFO with push/pop/full/empty/count/head outputs.
- The request queue reuses the team's normal val/rdy queue.

Test Plan:
- Single request, domain 1, addr 0x1000; memory ready; response 1 cycle later -> req_out_val at cycle +1, outstanding 1 then 0, resp_domain=1 with resp_out_val.
- Requests with domains 0,1,1,0 issued back-to-back; memory holds responses -> outstanding reaches 4, fifth request held (req_out_val=0) until first response; responses tagged 0,1,1,0 in order.
- req_out_rdy=0 with 2 requests enqueued -> req_in_rdy=0 on third; rdy=1 restores throughput of 1 per cycle.
- resp_in_val=1 with outstanding=0 -> resp_out_val=0, resp_in_rdy=1, spurious_resp=1 and stays set.
- Same-cycle issue and response at outstanding=2 -> outstanding stays 2, head domain advances correctly across pointer wrap after 6+ requests.
- Assert reset with 3 in flight -> outstanding=0, all val outputs 0 immediately (async); a later stale response sets spurious_resp.
